// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 5x5 unsigned multiplier accumulating through one five_bit_adder.
module five_bit_adder (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [4:0] s,
  output logic       c
);
  assign {c, s} = {1'b0, x} + {1'b0, y};
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, acc_q, acc_d, q_q, q_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0] sum;
  logic carry;
  five_bit_adder u_add (
    .x(acc_q),
    .y(q_q[0] ? m_q : '0),
    .s(sum),
    .c(carry)
  );
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: if (start) begin
        m_d     = a;
        q_d     = b;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = {carry, sum[WIDTH-1:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d   = DONE;
          product_d = {acc_d, q_d};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  assign busy    = state_q == RUN;
  assign done    = state_q == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed and exhaustive checks with a product scoreboard.
module tb_shift_add_multiplier;
  logic clk = 0, rst = 1, start = 0;
  logic [4:0] a = 0, b = 0;
  logic busy, done;
  logic [9:0] product;
  logic [9:0] sb[$];
  logic [9:0] exp_prev = 0;
  int checks = 0, errors = 0, done_cnt = 0, accepted = 0, cyc = 0, last_done = -1;

  shift_add_multiplier dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("product", product, sb.pop_front());
    end
  endtask

  task automatic push(input logic [4:0] x, input logic [4:0] y);
    logic [9:0] e;
    e = 10'(x) * 10'(y);
    sb.push_back(e);
    accepted++;
  endtask

  task automatic do_op(input logic [4:0] x, input logic [4:0] y, input bit disturb);
    logic [9:0] e;
    e = 10'(x) * 10'(y);
    a = x; b = y; start = 1;
    push(x, y);
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      chk("run_busy", busy, 1);
      chk("run_done", done, 0);
      chk("run_hold", product, exp_prev);
      if (disturb) begin
        start = i[0];
        a = 5'($urandom);
        b = 5'($urandom);
      end
      tick();
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_prod", product, e);
    exp_prev = e;
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_prod", product, 0);

    do_op(31, 31, 0);
    chk("max_prod", product, 961);
    do_op(0, 19, 0);
    do_op(19, 0, 0);
    do_op(13, 11, 1);
    chk("ignored_start", busy, 0);
    chk("disturb_prod", product, 143);

    begin
      int base, pulses;
      base = done_cnt;
      last_done = -1;
      a = 5; b = 6; start = 1;
      for (int i = 0; i < 4; i++) push(5, 6);
      for (int i = 0; i < 22; i++) begin
        tick();
        if (done) begin
          if (last_done >= 0) chk("held_gap", cyc - last_done, 7);
          last_done = cyc;
        end
        if (busy && done_cnt > base) chk("held_prev", product, 30);
      end
      start = 0;
      for (int i = 0; i < 10; i++) tick();
      pulses = done_cnt - base;
      chk("held_pulses", pulses, 4);
      exp_prev = 30;
    end

    a = 7; b = 9; start = 1;
    push(7, 9);
    tick();
    start = 0;
    tick();
    tick();
    chk("abort_busy_pre", busy, 1);
    rst = 1;
    void'(sb.pop_back());
    accepted--;
    tick();
    rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_prod", product, 0);
    exp_prev = 0;
    do_op(7, 9, 0);
    chk("fresh_prod", product, 63);

    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        bit seen;
        seen = 0;
        a = 5'(i); b = 5'(j); start = 1;
        push(5'(i), 5'(j));
        tick();
        start = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
          tick();
          seen = done;
        end
        chk("sweep_done_seen", seen, 1);
        tick();
      end
    end

    tick();
    chk("sb_empty", sb.size(), 0);
    chk("done_count", done_cnt, accepted);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
